// File: rtl/keypad_debounce.sv
// keypad_debounce: synchronise, debounce and priority-encode push buttons into one-cycle key events.
module keypad_debounce #(
    parameter int NKEYS           = 20,
    parameter int DEBOUNCE_CYCLES = 5,
    parameter int CW              = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] pb_in,
    output logic             key_valid,
    output logic [CW-1:0]    key_code,
    output logic             key_held,
    output logic             multi_err
);
    localparam int CNTW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNTW-1:0] LAST = CNTW'(DEBOUNCE_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
    state_t           state_q, state_d;
    logic [NKEYS-1:0] sync1, sync;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]    cand_q, cand_d, code, code_d;
    logic             any, multi, valid_d, held_d;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync  <= '0;
        end else begin
            sync1 <= pb_in;
            sync  <= sync1;
        end
    end
    // multi is set when a bit is seen after an earlier one, i.e. popcount >= 2
    always_comb begin
        any   = 1'b0;
        multi = 1'b0;
        code  = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (sync[i]) begin
                multi = multi | any;
                any   = 1'b1;
                code  = CW'(i);
            end
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        valid_d = 1'b0;
        code_d  = key_code;
        held_d  = key_held;
        case (state_q)
            IDLE:
                if (any && !multi) begin
                    cand_d  = code;
                    cnt_d   = '0;
                    state_d = PRESS_WAIT;
                end
            PRESS_WAIT:
                if (!any || multi || code != cand_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    code_d  = cand_q;
                    held_d  = 1'b1;
                end else cnt_d = cnt_q + 1'b1;
            PRESSED:
                if (!any) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            RELEASE_WAIT:
                if (any) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    held_d  = 1'b0;
                end else cnt_d = cnt_q + 1'b1;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cand_q    <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_held  <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            key_valid <= valid_d;
            key_code  <= code_d;
            key_held  <= held_d;
            multi_err <= multi;
        end
    end
endmodule

// File: tb/tb_keypad_debounce.sv
// tb_keypad_debounce: directed stimulus with a scoreboard of expected key events (code and edge).
module tb_keypad_debounce;
    localparam int NKEYS = 20;
    localparam int CW    = 5;
    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NKEYS-1:0] pb_in = '0;
    logic             key_valid, key_held, multi_err;
    logic [CW-1:0]    key_code;
    typedef struct {
        logic [CW-1:0] code;
        int            cyc;
    } ev_t;
    ev_t  q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_valid = 1'b0;
    keypad_debounce #(.NKEYS(NKEYS), .DEBOUNCE_CYCLES(5), .CW(CW)) dut (
        .clk(clk), .rst(rst), .pb_in(pb_in),
        .key_valid(key_valid), .key_code(key_code), .key_held(key_held), .multi_err(multi_err)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic expect_event(input logic [CW-1:0] code);
        ev_t e;
        e.code = code;
        e.cyc  = cyc + 8;
        q.push_back(e);
    endtask
    always @(negedge clk) begin
        if (key_valid) begin
            check("valid_not_back_to_back", {31'd0, prev_valid}, 32'd0);
            if (q.size() == 0) check("unexpected_key_valid", 32'd1, 32'd0);
            else begin
                ev_t e;
                e = q.pop_front();
                check("event_code", {27'd0, key_code}, {27'd0, e.code});
                check("event_edge", cyc, e.cyc);
            end
        end
        prev_valid = key_valid;
    end
    initial begin
        #1;
        check("rst_valid", {31'd0, key_valid}, 32'd0);
        check("rst_held", {31'd0, key_held}, 32'd0);
        check("rst_code", {27'd0, key_code}, 32'd0);
        check("rst_multi", {31'd0, multi_err}, 32'd0);
        step(3);
        rst = 1'b1;
        pb_in[5] = 1'b1;
        step(3);
        pb_in = '0;
        step(12);
        check("short_held", {31'd0, key_held}, 32'd0);
        check("short_code", {27'd0, key_code}, 32'd0);
        pb_in = NKEYS'(1) << 7;
        expect_event(5'd7);
        step(7);
        check("p7_held_early", {31'd0, key_held}, 32'd0);
        step(1);
        check("p7_held", {31'd0, key_held}, 32'd1);
        check("p7_valid", {31'd0, key_valid}, 32'd1);
        check("p7_code", {27'd0, key_code}, 32'd7);
        step(1);
        check("p7_valid_drop", {31'd0, key_valid}, 32'd0);
        pb_in = '0;
        step(7);
        check("p7_rel_early", {31'd0, key_held}, 32'd1);
        step(1);
        check("p7_rel", {31'd0, key_held}, 32'd0);
        pb_in = NKEYS'(1) << 3; step(1);
        pb_in = '0;             step(1);
        pb_in = NKEYS'(1) << 3; step(1);
        pb_in = '0;             step(1);
        pb_in = NKEYS'(1) << 3;
        expect_event(5'd3);
        step(12);
        check("b3_code", {27'd0, key_code}, 32'd3);
        check("b3_held", {31'd0, key_held}, 32'd1);
        pb_in = '0;
        step(10);
        check("b3_rel", {31'd0, key_held}, 32'd0);
        pb_in = NKEYS'(1) << 16;
        expect_event(5'd16);
        step(40);
        pb_in = '0;
        step(2);
        pb_in = NKEYS'(1) << 16;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("drop_held", {31'd0, key_held}, 32'd1);
        end
        step(48);
        check("p16_code", {27'd0, key_code}, 32'd16);
        pb_in = '0;
        step(10);
        check("p16_rel", {31'd0, key_held}, 32'd0);
        pb_in = (NKEYS'(1) << 2) | (NKEYS'(1) << 9);
        step(2);
        check("multi_early", {31'd0, multi_err}, 32'd0);
        step(1);
        check("multi_set", {31'd0, multi_err}, 32'd1);
        step(10);
        check("multi_no_held", {31'd0, key_held}, 32'd0);
        pb_in = NKEYS'(1) << 2;
        expect_event(5'd2);
        step(3);
        check("multi_clear", {31'd0, multi_err}, 32'd0);
        step(7);
        check("p2_code", {27'd0, key_code}, 32'd2);
        check("p2_held", {31'd0, key_held}, 32'd1);
        pb_in = '0;
        step(10);
        pb_in = NKEYS'(1) << 12;
        step(4);
        rst = 1'b0;
        #2;
        check("arst_valid", {31'd0, key_valid}, 32'd0);
        check("arst_held", {31'd0, key_held}, 32'd0);
        check("arst_code", {27'd0, key_code}, 32'd0);
        check("arst_multi", {31'd0, multi_err}, 32'd0);
        step(1);
        rst = 1'b1;
        expect_event(5'd12);
        step(10);
        check("p12_code", {27'd0, key_code}, 32'd12);
        check("p12_held", {31'd0, key_held}, 32'd1);
        pb_in = '0;
        step(10);
        check("p12_rel", {31'd0, key_held}, 32'd0);
        check("events_pending", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
